// File: rtl/multicore_system_ram_arb_pkg.sv
// Shared types and constants for the two-requester system RAM arbiter.
package multicore_system_ram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    // Width of the lock tenure counter; at least one bit even when tenure is unlimited.
    function automatic int tenure_w(input int max_lock);
        int w;
        w = $clog2(max_lock + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/multicore_system_rr_arb2.sv
// Two-way contention resolver for the system RAM arbiter.
// Policy selected by MULTICORE_SYSTEM_RAM_ARB_RR_EN: defined gives round-robin
// (winner is the requester that was not granted last), undefined gives fixed
// priority with m0 winning. A pending forced-release hand-over beats either policy.
module multicore_system_rr_arb2
    import multicore_system_ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last,
    input  req_id_t    i_force_id,
    input  logic       i_force_valid,
    output logic [1:0] o_gnt
);

`ifdef MULTICORE_SYSTEM_RAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    req_id_t w_winner;

    // Resolve contention first, then fall back to whichever single requester is pending.
    always_comb begin
        w_winner = 1'b0;
        o_gnt    = 2'b00;
        if (i_force_valid) begin
            w_winner = i_force_id;
        end else if (RR_EN) begin
            w_winner = ~i_last;
        end
        if (i_req == 2'b11) begin
            o_gnt = w_winner ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/multicore_system_ram_arbiter.sv
// Shares one single-port byte-enabled RAM between two Avalon-MM requesters,
// with arbitration lock for atomic read-modify-write and bounded lock tenure.
// Contention policy comes from MULTICORE_SYSTEM_RAM_ARB_RR_EN (see multicore_system_rr_arb2).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// UNLOCKED | both requesters arbitrate every cycle
// LOCKED   | only r_owner may be granted; r_tenure counts held cycles
module multicore_system_ram_arbiter
    import multicore_system_ram_arb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_LOCK_CYCLES = 16
)(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_reset_req,

    input  logic [ADDR_W-1:0]     i_m0_address,
    input  logic [DATA_W/8-1:0]   i_m0_byteenable,
    input  logic                  i_m0_read,
    input  logic                  i_m0_write,
    input  logic [DATA_W-1:0]     i_m0_writedata,
    input  logic                  i_m0_lock,
    output logic                  o_m0_waitrequest,
    output logic [DATA_W-1:0]     o_m0_readdata,
    output logic                  o_m0_readdatavalid,

    input  logic [ADDR_W-1:0]     i_m1_address,
    input  logic [DATA_W/8-1:0]   i_m1_byteenable,
    input  logic                  i_m1_read,
    input  logic                  i_m1_write,
    input  logic [DATA_W-1:0]     i_m1_writedata,
    input  logic                  i_m1_lock,
    output logic                  o_m1_waitrequest,
    output logic [DATA_W-1:0]     o_m1_readdata,
    output logic                  o_m1_readdatavalid,

    output logic [ADDR_W-1:0]     o_ram_address,
    output logic [DATA_W/8-1:0]   o_ram_byteenable,
    output logic                  o_ram_chipselect,
    output logic                  o_ram_write,
    output logic [DATA_W-1:0]     o_ram_writedata,
    output logic                  o_ram_clken,
    input  logic [DATA_W-1:0]     i_ram_readdata
);

    localparam int BE_W          = DATA_W / 8;
    localparam int TENURE_W      = tenure_w(MAX_LOCK_CYCLES);
    localparam bit LOCK_LIMITED  = (MAX_LOCK_CYCLES != 0);
    // With a one-cycle limit the locking transfer itself uses up the whole tenure.
    localparam bit ENTRY_EXPIRES = (MAX_LOCK_CYCLES == 1);
    localparam logic [TENURE_W:0] LP_MAX = (TENURE_W + 1)'(MAX_LOCK_CYCLES);

    arb_state_t          r_state;
    req_id_t             r_owner;
    req_id_t             r_last;
    req_id_t             r_force_id;
    logic                r_force_valid;
    logic [TENURE_W-1:0] r_tenure;
    logic                r_rd_pend;
    req_id_t             r_rd_id;
    logic [ADDR_W-1:0]   r_addr_hold;

    logic [1:0]          w_req;
    logic [1:0]          w_arb_gnt;
    logic [1:0]          w_gnt;
    logic                w_any;
    req_id_t             w_sel;
    logic                w_sel_write;
    logic                w_sel_lock;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [BE_W-1:0]     w_sel_be;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_owner_lock;
    logic [TENURE_W:0]   w_tenure_inc;
    logic                w_expire;

    assign w_req = {i_m1_read | i_m1_write, i_m0_read | i_m0_write};

    multicore_system_rr_arb2 u_arb (
        .i_req         (w_req),
        .i_last        (r_last),
        .i_force_id    (r_force_id),
        .i_force_valid (r_force_valid),
        .o_gnt         (w_arb_gnt)
    );

    // Grant: nothing during reset or reset_req, owner only while locked.
    always_comb begin
        w_gnt = 2'b00;
        if (!i_reset && !i_reset_req) begin
            if (r_state == LOCKED) begin
                w_gnt = w_req & (r_owner ? 2'b10 : 2'b01);
            end else begin
                w_gnt = w_arb_gnt;
            end
        end
    end

    assign w_any        = |w_gnt;
    assign w_sel        = w_gnt[1];
    // Read and write together is treated as a write.
    assign w_sel_write  = w_sel ? i_m1_write      : i_m0_write;
    assign w_sel_lock   = w_sel ? i_m1_lock       : i_m0_lock;
    assign w_sel_addr   = w_sel ? i_m1_address    : i_m0_address;
    assign w_sel_be     = w_sel ? i_m1_byteenable : i_m0_byteenable;
    assign w_sel_wdata  = w_sel ? i_m1_writedata  : i_m0_writedata;
    assign w_owner_lock = r_owner ? i_m1_lock : i_m0_lock;

    assign w_tenure_inc = {1'b0, r_tenure} + (TENURE_W + 1)'(1);
    assign w_expire     = LOCK_LIMITED && (w_tenure_inc >= LP_MAX);

    assign o_m0_waitrequest = w_req[0] & ~w_gnt[0];
    assign o_m1_waitrequest = w_req[1] & ~w_gnt[1];

    // Address holds when idle so the RAM address bus does not toggle needlessly.
    assign o_ram_address    = w_any ? w_sel_addr : r_addr_hold;
    assign o_ram_byteenable = w_sel_be;
    assign o_ram_chipselect = w_any;
    assign o_ram_write      = w_any & w_sel_write;
    assign o_ram_writedata  = w_sel_wdata;
    assign o_ram_clken      = 1'b1;

    assign o_m0_readdata      = i_ram_readdata;
    assign o_m1_readdata      = i_ram_readdata;
    // Reset discards a read that is still in flight.
    assign o_m0_readdatavalid = r_rd_pend & (r_rd_id == 1'b0) & ~i_reset;
    assign o_m1_readdatavalid = r_rd_pend & (r_rd_id == 1'b1) & ~i_reset;

    // Lock FSM, tenure tracking and read-return bookkeeping; all frozen by reset_req.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= UNLOCKED;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_force_id    <= 1'b0;
            r_force_valid <= 1'b0;
            r_tenure      <= '0;
            r_rd_pend     <= 1'b0;
            r_rd_id       <= 1'b0;
            r_addr_hold   <= '0;
        end else begin
            if (w_any) begin
                r_addr_hold <= w_sel_addr;
            end
            r_rd_pend <= w_any & ~w_sel_write;
            if (w_any && !w_sel_write) begin
                r_rd_id <= w_sel;
            end
            if (!i_reset_req) begin
                case (r_state)
                    UNLOCKED: begin
                        r_force_valid <= 1'b0;
                        if (w_any) begin
                            r_last <= w_sel;
                            if (w_sel_lock) begin
                                r_owner <= w_sel;
                                if (ENTRY_EXPIRES) begin
                                    r_force_valid <= 1'b1;
                                    r_force_id    <= ~w_sel;
                                end else begin
                                    r_state  <= LOCKED;
                                    r_tenure <= TENURE_W'(1);
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (!w_owner_lock) begin
                            r_state  <= UNLOCKED;
                            r_tenure <= '0;
                        end else if (w_expire) begin
                            r_state       <= UNLOCKED;
                            r_tenure      <= '0;
                            r_force_valid <= 1'b1;
                            r_force_id    <= ~r_owner;
                        end else begin
                            r_tenure <= w_tenure_inc[TENURE_W-1:0];
                        end
                    end
                    default: r_state <= UNLOCKED;
                endcase
            end
        end
    end

    // Read and write together on one port is a requester bug.
    a_m0_rw_excl: assert property (@(posedge i_clk) disable iff (i_reset) !(i_m0_read && i_m0_write));
    a_m1_rw_excl: assert property (@(posedge i_clk) disable iff (i_reset) !(i_m1_read && i_m1_write));

endmodule

// File: tb/tb_multicore_system_ram_arbiter.sv
// Scoreboard bench for multicore_system_ram_arbiter; works in either policy build
// (MULTICORE_SYSTEM_RAM_ARB_RR_EN defined or not).
module tb_multicore_system_ram_arbiter;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int BW     = 4;
    localparam int TB_MAX = 5;

    logic clk = 1'b0;
    logic reset, reset_req;

    logic [AW-1:0] m_addr  [2];
    logic [BW-1:0] m_be    [2];
    logic          m_rd    [2];
    logic          m_wr    [2];
    logic [DW-1:0] m_wdata [2];
    logic          m_lock  [2];
    logic          m_wait  [2];
    logic [DW-1:0] m_rdata [2];
    logic          m_rdv   [2];

    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_be;
    logic          ram_cs, ram_wr, ram_clken;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q = '0;

    logic [DW-1:0] ram_mem [1024] = '{default: 32'h0};
    logic [DW-1:0] ref_mem [1024] = '{default: 32'h0};

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } rd_exp_t;
    rd_exp_t exp_q [$];
    rd_exp_t mon_e;

    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;

    // reference model state
    int lock_holder = -1;
    int held = 0;
    int last = 1;
    int force_id = -1;

    int g, gp;

    multicore_system_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK_CYCLES(TB_MAX)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_reset_req        (reset_req),
        .i_m0_address       (m_addr[0]),
        .i_m0_byteenable    (m_be[0]),
        .i_m0_read          (m_rd[0]),
        .i_m0_write         (m_wr[0]),
        .i_m0_writedata     (m_wdata[0]),
        .i_m0_lock          (m_lock[0]),
        .o_m0_waitrequest   (m_wait[0]),
        .o_m0_readdata      (m_rdata[0]),
        .o_m0_readdatavalid (m_rdv[0]),
        .i_m1_address       (m_addr[1]),
        .i_m1_byteenable    (m_be[1]),
        .i_m1_read          (m_rd[1]),
        .i_m1_write         (m_wr[1]),
        .i_m1_writedata     (m_wdata[1]),
        .i_m1_lock          (m_lock[1]),
        .o_m1_waitrequest   (m_wait[1]),
        .o_m1_readdata      (m_rdata[1]),
        .o_m1_readdatavalid (m_rdv[1]),
        .o_ram_address      (ram_addr),
        .o_ram_byteenable   (ram_be),
        .o_ram_chipselect   (ram_cs),
        .o_ram_write        (ram_wr),
        .o_ram_writedata    (ram_wdata),
        .o_ram_clken        (ram_clken),
        .i_ram_readdata     (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered output, clock gated by reset_req, q held when not accessed.
    always @(posedge clk) begin
        if (ram_clken && ram_cs && !reset_req) begin
            if (ram_wr) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_q <= ram_mem[ram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-return monitor: pops the scoreboard whenever a valid strobe shows up or one is overdue.
    always @(negedge clk) begin
        if (m_rdv[0] || m_rdv[1]) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_readdatavalid", {m_rdv[1], m_rdv[0]}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                chk("readdatavalid_id", {m_rdv[1], m_rdv[0]}, (mon_e.id == 1) ? 2'b10 : 2'b01);
                chk("readdata", m_rdata[mon_e.id], mon_e.data);
                chk("read_latency", cyc, mon_e.due);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("missing_readdatavalid", {m_rdv[1], m_rdv[0]}, (mon_e.id == 1) ? 2'b10 : 2'b01);
        end
    end

    // Who should win this cycle, from the arbitration rules.
    function automatic int model_winner(input bit r0, input bit r1);
        bit r [2];
        r[0] = r0; r[1] = r1;
        if (reset || reset_req) return -1;
        if (lock_holder >= 0) return r[lock_holder] ? lock_holder : -1;
        if (r0 && r1) begin
            if (force_id >= 0) return force_id;
`ifdef MULTICORE_SYSTEM_RAM_ARB_RR_EN
            return 1 - last;
`else
            return 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic drive(input int n, input bit rd, input bit wr, input int addr,
                         input logic [31:0] d, input logic [3:0] be, input bit lk);
        m_rd[n] = rd; m_wr[n] = wr; m_addr[n] = AW'(addr);
        m_wdata[n] = d; m_be[n] = be; m_lock[n] = lk;
    endtask

    task automatic idle(input int n);
        drive(n, 0, 0, 0, 32'h0, 4'h0, 0);
    endtask

    // One bus cycle: inputs already driven; check at negedge, advance model, return DUT grant.
    task automatic step(output int dut_g);
        int w;
        bit r0, r1;
        if (reset) exp_q.delete();
        @(negedge clk);
        r0 = m_rd[0] | m_wr[0];
        r1 = m_rd[1] | m_wr[1];
        w = model_winner(r0, r1);
        chk("m0_waitrequest", m_wait[0], r0 && (w != 0));
        chk("m1_waitrequest", m_wait[1], r1 && (w != 1));
        chk("ram_chipselect", ram_cs, w >= 0);
        chk("ram_clken", ram_clken, 1);
        if (w >= 0) begin
            chk("ram_address", ram_addr, m_addr[w]);
            chk("ram_write", ram_wr, m_wr[w]);
            if (m_wr[w]) begin
                chk("ram_writedata", ram_wdata, m_wdata[w]);
                chk("ram_byteenable", ram_be, m_be[w]);
            end
        end
        if (!ram_cs) dut_g = -1;
        else if (r1 && !m_wait[1]) dut_g = 1;
        else if (r0 && !m_wait[0]) dut_g = 0;
        else dut_g = -2;

        if (reset) begin
            lock_holder = -1; held = 0; last = 1; force_id = -1;
        end else if (!reset_req) begin
            if (w >= 0) begin
                if (m_wr[w]) begin
                    for (int b = 0; b < BW; b++)
                        if (m_be[w][b]) ref_mem[m_addr[w]][8*b +: 8] = m_wdata[w][8*b +: 8];
                end else begin
                    exp_q.push_back('{w, ref_mem[m_addr[w]], cyc + 1});
                end
            end
            if (lock_holder < 0) begin
                force_id = -1;
                if (w >= 0) begin
                    last = w;
                    if (m_lock[w]) begin
                        if (TB_MAX == 1) force_id = 1 - w;
                        else begin lock_holder = w; held = 1; end
                    end
                end
            end else if (!m_lock[lock_holder]) begin
                lock_holder = -1;
            end else begin
                held++;
                if (TB_MAX != 0 && held >= TB_MAX) begin
                    force_id = 1 - lock_holder;
                    lock_holder = -1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; reset_req = 0;
        idle(0); idle(1);
        repeat (3) step(g);
        reset = 0;
        step(g);

        // write then read back through m0
        drive(0, 0, 1, 'h005, 32'hDEADBEEF, 4'hF, 0);
        step(g); chk("s1_write_grant", g, 0);
        drive(0, 1, 0, 'h005, 32'h0, 4'hF, 0);
        step(g); chk("s1_read_grant", g, 0);
        idle(0); step(g);

        // both reading every cycle
        drive(0, 1, 0, 'h010, 32'h0, 4'hF, 0);
        drive(1, 1, 0, 'h020, 32'h0, 4'hF, 0);
        gp = -1;
        for (int i = 0; i < 8; i++) begin
            step(g);
`ifdef MULTICORE_SYSTEM_RAM_ARB_RR_EN
            if (i > 0) chk("s2_rr_alternate", (g != gp) && (g >= 0), 1);
`else
            chk("s2_fixed_m0", g, 0);
`endif
            gp = g;
        end
        idle(0); idle(1); step(g);

        // lock held through idle cycles, released by unlocked write
        drive(1, 1, 0, 'h100, 32'h0, 4'hF, 1);
        step(g); chk("s3_lock_grant", g, 1);
        drive(1, 0, 0, 'h100, 32'h0, 4'h0, 1);
        drive(0, 0, 1, 'h200, 32'h12345678, 4'hF, 0);
        repeat (3) begin step(g); chk("s3_locked_idle", g, -1); end
        drive(1, 0, 1, 'h100, 32'hCAFEF00D, 4'hF, 0);
        step(g); chk("s3_unlock_write", g, 1);
        idle(1);
        step(g); chk("s3_m0_after_unlock", g, 0);
        idle(0); step(g);

        // tenure limit forces hand-over
        drive(1, 1, 0, 'h030, 32'h0, 4'hF, 1);
        step(g); chk("s4_lock_grant", g, 1);
        drive(0, 1, 0, 'h031, 32'h0, 4'hF, 0);
        for (int i = 1; i <= TB_MAX; i++) begin
            step(g);
            chk("s4_tenure", g, (i < TB_MAX) ? 1 : 0);
        end
        idle(0); idle(1); step(g);

        // reset discards in-flight read; m0 wins first contention afterwards
        drive(0, 1, 0, 'h005, 32'h0, 4'hF, 0);
        step(g); chk("s5_read_grant", g, 0);
        idle(0); reset = 1;
        step(g); step(g);
        reset = 0;
        drive(0, 1, 0, 'h010, 32'h0, 4'hF, 0);
        drive(1, 1, 0, 'h020, 32'h0, 4'hF, 0);
        step(g); chk("s5_first_after_reset", g, 0);

        // reset_req blocks grants but lets the prior read return
        step(g);
        reset_req = 1;
        repeat (5) begin step(g); chk("s6_no_grant", g, -1); end
        reset_req = 0;
        step(g); chk("s6_resume", g >= 0, 1);
        idle(0); idle(1); step(g);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            reset_req = ($urandom_range(0, 24) == 0);
            for (int n = 0; n < 2; n++) begin
                int k;
                k = $urandom_range(0, 3);
                drive(n, (k == 1) || (k == 3), k == 2, $urandom_range(0, 15),
                      $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
            end
            step(g);
        end
        reset = 0; reset_req = 0;
        idle(0); idle(1);
        repeat (4) step(g);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/multicore_system_ram_arbiter.md
Name: multicore_system_ram_arbiter

Overview:
- Shares one single-port per-core on-chip RAM (1024x32, byte-enabled, read data one cycle after the address is registered) between two Avalon-MM requesters.
- Typical pairing: the local core's data master (m0) and the inter-core mailbox/DMA master (m1).
- Issues at most one RAM access per cycle and returns read data with a valid strobe to the owning requester.
- Supports Avalon arbitration lock for atomic read-modify-write, with bounded lock tenure.

Parameters:
- ADDR_W, 10, word address width to RAM
- DATA_W, 32, data width; BE_W = DATA_W/8 is derived, not overridable
- MAX_LOCK_CYCLES, 16, max consecutive cycles one requester may hold a lock; 0 = unlimited

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  reset pending; stops new grants
- mN_address  in  ADDR_W  requester N word address (N = 0, 1; same for all mN_ ports)
- mN_byteenable  in  BE_W  byte lanes for writes
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_writedata  in  DATA_W  write data
- mN_lock  in  1  keep grant after this transfer
- mN_waitrequest  out  1  request not accepted this cycle
- mN_readdata  out  DATA_W  read data (broadcast)
- mN_readdatavalid  out  1  mN_readdata valid for requester N
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  BE_W  to RAM
- ram_chipselect  out  1  access strobe
- ram_write  out  1  write strobe
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  RAM clock enable
- ram_readdata  in  DATA_W  from RAM, valid the cycle after the access

Behaviour:
- req_N = mN_read | mN_write. If both are high, treat as write; simulation assertion fires.
- Grant is combinational each cycle: gnt_N = 1 means requester N's transfer is accepted and driven to the RAM. mN_waitrequest = req_N & ~gnt_N. Idle requesters see waitrequest 0.
- ram_* mirror the granted requester's signals. ram_chipselect = |gnt; ram_write = granted write. With no grant, chipselect = 0 and ram_address holds its last value.
- ram_clken is constant 1; the RAM gates its own clock enable with reset_req.
- State machine (registered): UNLOCKED, LOCKED. Registers: owner (1 bit), last (1 bit), tenure counter, rd_pend, rd_id.
- UNLOCKED arbitration: if only one requester is pending, grant it. If both are pending, apply the arbitration policy (see Optional Feature). last <= granted id.
- UNLOCKED -> LOCKED: granted transfer has mN_lock = 1. Then owner <= N, tenure <= 1.
- LOCKED: only owner may be granted; the other requester waits even if the owner is idle. tenure increments every cycle in LOCKED.
- LOCKED -> UNLOCKED on any of:
  - owner's granted transfer has lock = 0 (that transfer still completes);
  - owner has lock = 0 and no request in a cycle;
  - tenure == MAX_LOCK_CYCLES (MAX_LOCK_CYCLES != 0). Forced release; in the next cycle the non-owner, if pending, wins regardless of policy.
- Writes complete in the grant cycle; no response.
- Reads: granted read sets rd_pend <= 1, rd_id <= N. Next cycle mN_readdatavalid = rd_pend & (rd_id == N), mN_readdata = ram_readdata.
  - Latency: request accepted in cycle T, data in cycle T+1.
  - Back-to-back reads from either or both requesters give throughput 1 per cycle.
- reset_req = 1: no new grants; waitrequest = req_N for both ports. A read granted the cycle before still returns its data (RAM holds q while clock is disabled). Lock state and tenure freeze.
- reset (sync): state UNLOCKED, last = 1 (m0 wins the first contention), tenure = 0, rd_pend = 0, all readdatavalid = 0.
  - While reset is high: no grants, waitrequest = req_N.
  - An in-flight read is discarded (no valid strobe). Lock is cleared.

Optional Feature:
- Macro: MULTICORE_SYSTEM_RAM_ARB_RR_EN.
- Defined: round-robin on contention; winner is the requester != last.
- Undefined: fixed priority, m0 always wins contention; last is still maintained for the forced-release rule. Lock and tenure behave identically in both builds.

Decomposition:
- Package multicore_system_ram_arb_pkg: state enum {UNLOCKED, LOCKED}, requester-id typedef (1 bit), default ADDR_W/DATA_W constants, TENURE_W = $clog2(MAX_LOCK_CYCLES+1) helper function.
- Sub-module multicore_system_rr_arb2: 2-way arbiter taking req[1:0], last, force_id, force_valid and returning gnt[1:0]. The policy macro is evaluated only inside it.

Test Plan:
- m0 write addr 0x005 data 0xDEADBEEF be 0xF, then m0 read 0x005 -> waitrequest 0 both cycles; m0_readdatavalid=1 with 0xDEADBEEF one cycle after read accept; m1_readdatavalid stays 0.
- Both read every cycle (m0 addr 0x010, m1 addr 0x020), RR build -> grants alternate m0,m1,m0…; each valid T+1 with correct data. Fixed build -> m0 granted every cycle, m1 waitrequest held 1.
- m1 locked read 0x100, locked idle 3 cycles, unlocked write 0x100 while m0 requests -> m0 waitrequest 1 throughout; m0 granted the cycle after m1's unlocked write.
- m1 holds lock with continuous requests, MAX_LOCK_CYCLES=4, m0 pending -> m1 granted 4 cycles, then m0 granted next cycle.
- m0 read accepted, reset asserted next cycle -> no m0_readdatavalid; after reset, m0 and m1 contend -> m0 granted first.
- reset_req high for 5 cycles with both requesting, read granted the cycle before -> that read's valid is delivered; no ram_chipselect during reset_req; arbitration resumes the cycle after it drops.
